// File: rtl/axi_arbiter_wr.sv
// Two-master AXI write-path arbiter: AW grant, W-channel lock until WLAST, in-order B routing FIFO.
// Define AXI_WR_ARB_FIXED_PRIO_EN to make m0 win every IDLE tie instead of round-robin.
module axi_arbiter_wr #(
    parameter int BFIFO_DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic m0_AWVALID,
    input  logic m1_AWVALID,
    input  logic awready,
    input  logic wvalid,
    input  logic wready,
    input  logic wlast,
    input  logic bvalid,
    input  logic bready,
    output logic m0_wgrnt,
    output logic m1_wgrnt,
    output logic w_sel,
    output logic w_sel_valid,
    output logic b_sel,
    output logic b_sel_valid,
    output logic bfifo_full
);

    localparam int PW = $clog2(BFIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_q, last_d;

    logic [PW:0]            wr_ptr_q, rd_ptr_q;
    logic [BFIFO_DEPTH-1:0] bfifo_q;

    logic aw_hs, w_last_hs, push, pop, empty, full;

    assign aw_hs     = (gnt_q ? m1_AWVALID : m0_AWVALID) & awready;
    assign w_last_hs = wvalid & wready & wlast;
    assign push      = (state_q == DATA) & w_last_hs;

    // Pointers carry one extra bit so equal indices can be told apart as empty or full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop   = bvalid & bready & ~empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        m0_wgrnt    = 1'b0;
        m1_wgrnt    = 1'b0;
        w_sel       = gnt_q;
        w_sel_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!full) begin
                    unique case ({m1_AWVALID, m0_AWVALID})
                        2'b01: begin
                            gnt_d   = 1'b0;
                            state_d = ADDR;
                        end
                        2'b10: begin
                            gnt_d   = 1'b1;
                            state_d = ADDR;
                        end
                        2'b11: begin
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
                            gnt_d   = 1'b0;
`else
                            gnt_d   = ~last_q;
`endif
                            state_d = ADDR;
                        end
                        default: ;
                    endcase
                end
            end
            ADDR: begin
                m0_wgrnt = ~gnt_q;
                m1_wgrnt = gnt_q;
                if (aw_hs) state_d = DATA;
            end
            DATA: begin
                w_sel_valid = 1'b1;
                if (w_last_hs) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the FIFO storage is reset too; it is only a few bits and keeps b_sel at 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            bfifo_q  <= '0;
        end else begin
            if (push) begin
                bfifo_q[wr_ptr_q[PW-1:0]] <= gnt_q;
                wr_ptr_q                  <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    assign b_sel       = bfifo_q[rd_ptr_q[PW-1:0]];
    assign b_sel_valid = ~empty;
    assign bfifo_full  = full;

endmodule
